// File: rtl/my_video_filter_acc_norm.sv
// Accumulates unsigned product groups, normalises each sum by SHIFT and saturates it to an OUT_W pixel.
// Optional round-half-up normalisation: define MY_VIDEO_FILTER_ACC_NORM_ROUND_EN.
module my_video_filter_acc_norm #(
    parameter int PROD_W   = 32,
    parameter int ACC_W    = 40,
    parameter int OUT_W    = 8,
    parameter int SHIFT    = 8,
    parameter int MAX_TAPS = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              prod_valid,
    input  logic              prod_last,
    output logic              prod_ready,
    output logic [OUT_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              taps_err
);

    localparam int CNT_W = $clog2(MAX_TAPS + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    localparam logic [ACC_W-1:0] PIX_MAX = ACC_W'({OUT_W{1'b1}});

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] pix_data_q, pix_data_d;
    logic             pix_valid_q, pix_valid_d;
    logic             taps_err_q, taps_err_d;

    logic             beat_acc;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] sum_sat;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit_max;
    logic             grp_close;
    logic [ACC_W-1:0] rnd_sum;
    logic [ACC_W-1:0] norm;
    logic [OUT_W-1:0] pix_next;

`ifdef MY_VIDEO_FILTER_ACC_NORM_ROUND_EN
    localparam logic [ACC_W-1:0] RND_HALF =
        (SHIFT == 0) ? '0 : (ACC_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0));
    logic [ACC_W:0] rnd_ext;
`endif

    // Ready is combinational from pix_ready so a pixel can drain and a new one load in one edge.
    assign prod_ready = !pix_valid_q || pix_ready;
    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign taps_err   = taps_err_q;

    always_comb begin
        beat_acc  = prod_valid && prod_ready;
        acc_base  = (state_q == ST_IDLE) ? '0 : acc_q;
        sum_ext   = {1'b0, acc_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_data};
        // Once saturated, any further nonzero add carries again, so all-ones is sticky.
        sum_sat   = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
        cnt_inc   = cnt_q + CNT_W'(1);
        hit_max   = (cnt_inc == CNT_W'(MAX_TAPS));
        grp_close = prod_last || hit_max;

`ifdef MY_VIDEO_FILTER_ACC_NORM_ROUND_EN
        rnd_ext = {1'b0, sum_sat} + {1'b0, RND_HALF};
        rnd_sum = rnd_ext[ACC_W] ? {ACC_W{1'b1}} : rnd_ext[ACC_W-1:0];
`else
        rnd_sum = sum_sat;
`endif

        norm     = rnd_sum >> SHIFT;
        pix_next = (norm > PIX_MAX) ? {OUT_W{1'b1}} : norm[OUT_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = pix_valid_q;
        taps_err_d  = taps_err_q;

        if (pix_valid_q && pix_ready) begin
            pix_valid_d = 1'b0;
        end

        if (beat_acc) begin
            if (grp_close) begin
                state_d     = ST_IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                pix_data_d  = pix_next;
                pix_valid_d = 1'b1;
                if (hit_max && !prod_last) begin
                    taps_err_d = 1'b1;
                end
            end else begin
                state_d = ST_ACCUM;
                acc_d   = sum_sat;
                cnt_d   = cnt_inc;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            taps_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            taps_err_q  <= taps_err_d;
        end
    end

endmodule

// File: tb/tb_my_video_filter_acc_norm.sv
// Scoreboard bench: accepted beats feed a sum/saturate model, a negedge monitor checks every pixel.
module tb_my_video_filter_acc_norm;

    localparam longint unsigned AMAX = (64'd1 << 40) - 1;

    logic        clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic [31:0] prod_data = '0;
    logic        prod_valid = 1'b0;
    logic        prod_last = 1'b0;
    logic        prod_ready;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        taps_err;

    logic [31:0] p2_data = '0;
    logic        p2_valid = 1'b0;
    logic        p2_last = 1'b0;
    logic        p2_ready;
    logic [7:0]  x2_data;
    logic        x2_valid;
    logic        x2_ready = 1'b1;
    logic        t2_err;

    int checks = 0;
    int errors = 0;

    logic [7:0]      exp_q[$];
    longint unsigned m_sum = 0;
    int              m_cnt = 0;
    logic            exp_taps = 1'b0;

    always #5 clk = ~clk;

    my_video_filter_acc_norm dut (
        .ap_clk(clk), .ap_rst(ap_rst),
        .prod_data(prod_data), .prod_valid(prod_valid), .prod_last(prod_last), .prod_ready(prod_ready),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .taps_err(taps_err)
    );

    my_video_filter_acc_norm #(.MAX_TAPS(512)) dut_long (
        .ap_clk(clk), .ap_rst(ap_rst),
        .prod_data(p2_data), .prod_valid(p2_valid), .prod_last(p2_last), .prod_ready(p2_ready),
        .pix_data(x2_data), .pix_valid(x2_valid), .pix_ready(x2_ready), .taps_err(t2_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] norm_px(input longint unsigned s);
        longint unsigned t, n;
        t = s;
`ifdef MY_VIDEO_FILTER_ACC_NORM_ROUND_EN
        t = t + 128;
        if (t > AMAX) t = AMAX;
`endif
        n = t / 256;
        return (n > 255) ? 8'hFF : n[7:0];
    endfunction

    // Reference model: one update per accepted beat.
    always @(posedge clk) begin
        if (ap_rst) begin
            exp_q.delete();
            m_sum = 0;
            m_cnt = 0;
            exp_taps = 1'b0;
        end else if (prod_valid && prod_ready) begin
            m_sum = m_sum + prod_data;
            if (m_sum > AMAX) m_sum = AMAX;
            m_cnt++;
            if (prod_last || m_cnt == 16) begin
                if (!prod_last) exp_taps = 1'b1;
                exp_q.push_back(norm_px(m_sum));
                m_sum = 0;
                m_cnt = 0;
            end
        end
    end

    logic       held_prev = 1'b0;
    logic       rst_prev = 1'b1;
    logic [7:0] data_prev = '0;

    always @(negedge clk) begin
        chk("pix_valid_vs_pending", pix_valid, exp_q.size() != 0);
        chk("prod_ready_rule", prod_ready, !pix_valid || pix_ready);
        chk("taps_err", taps_err, exp_taps);
        if (held_prev && !rst_prev) begin
            chk("hold_valid", pix_valid, 1'b1);
            chk("hold_data", pix_data, data_prev);
        end
        if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel: got %0h expected none", pix_data);
            end else begin
                chk("pix_data", pix_data, exp_q.pop_front());
            end
        end
        held_prev = pix_valid && !pix_ready;
        data_prev = pix_data;
        rst_prev  = ap_rst;
    end

    // Presents one beat and returns just after the edge that accepted it.
    task automatic beat(input logic [31:0] d, input logic l);
        int n = 0;
        prod_valid = 1'b1;
        prod_data  = d;
        prod_last  = l;
        @(negedge clk);
        while (!prod_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
            if (n >= 3) pix_ready = 1'b1;
            @(negedge clk);
        end
        if (!prod_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got prod_ready=0 expected 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1 ap_rst = 1'b0;
        #3;
        chk("rst_pix_valid", pix_valid, 1'b0);
        chk("rst_pix_data", pix_data, 8'h00);
        chk("rst_taps_err", taps_err, 1'b0);
        chk("rst_prod_ready", prod_ready, 1'b1);
        @(posedge clk); #1;

        // Basic 9-beat group
        for (int i = 0; i < 9; i++) beat(32'h0000_1000, i == 8);
        idle();
        #3;
        chk("basic_valid", pix_valid, 1'b1);
        chk("basic_data", pix_data, 8'h90);
        @(posedge clk); #3;
        chk("basic_one_cycle", pix_valid, 1'b0);
        @(posedge clk); #1;

        beat(32'hFFFE_0001, 1'b0);
        beat(32'hFFFE_0001, 1'b1);
        idle();
        #3 chk("sat_data", pix_data, 8'hFF);
        @(posedge clk); #1;

        beat(32'h0000_0180, 1'b1);
        idle();
`ifdef MY_VIDEO_FILTER_ACC_NORM_ROUND_EN
        #3 chk("round_data", pix_data, 8'h02);
`else
        #3 chk("round_data", pix_data, 8'h01);
`endif
        @(posedge clk); #1;

        // Backpressure: second group stalls until the first pixel drains
        pix_ready = 1'b0;
        beat(32'h0000_0300, 1'b1);
        prod_valid = 1'b1;
        prod_data  = 32'h0000_0400;
        prod_last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_stall", prod_ready, 1'b0);
        end
        @(posedge clk); #1 pix_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", prod_ready, 1'b1);
        chk("bp_release_data", pix_data, 8'h03);
        @(posedge clk); #1;
        for (int i = 5; i <= 9; i++) beat(32'(i) << 8, 1'b1);
        idle();
        @(posedge clk); #1;

        // Forced close at 16 beats
        for (int i = 0; i < 20; i++) begin
            beat(32'h0000_0100, 1'b0);
            if (i == 15) begin
                #3;
                chk("force_data", pix_data, 8'h10);
                chk("force_valid", pix_valid, 1'b1);
                chk("force_taps_err", taps_err, 1'b1);
            end
        end
        beat(32'h0000_0100, 1'b1);
        idle();
        #3;
        chk("force_next_group", pix_data, 8'h05);
        chk("force_taps_sticky", taps_err, 1'b1);
        @(posedge clk); #1;

        // Reset in the middle of a group
        for (int i = 0; i < 4; i++) beat(32'h0001_0000, 1'b0);
        idle();
        ap_rst = 1'b1;
        @(posedge clk); #1 ap_rst = 1'b0;
        #3;
        chk("midrst_valid", pix_valid, 1'b0);
        chk("midrst_taps_err", taps_err, 1'b0);
        @(posedge clk); #1;
        beat(32'h0000_0200, 1'b1);
        idle();
        #3 chk("midrst_data", pix_data, 8'h02);
        @(posedge clk); #1;

        // Randomized traffic with random backpressure
        repeat (400) begin
            pix_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) begin
                idle();
                @(posedge clk); #1;
            end else begin
                beat(($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2000)),
                     $urandom_range(0, 5) == 0);
            end
        end
        idle();
        pix_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);

        // Long group on the MAX_TAPS=512 instance saturates the accumulator
        for (int i = 1; i <= 300; i++) begin
            p2_valid = 1'b1;
            p2_data  = 32'hFFFF_FFFF;
            p2_last  = (i == 300);
            @(posedge clk); #1;
            if (i == 299) chk("long_no_early_close", x2_valid, 1'b0);
        end
        p2_valid = 1'b0;
        p2_last  = 1'b0;
        #3;
        chk("long_valid", x2_valid, 1'b1);
        chk("long_data", x2_data, 8'hFF);
        chk("long_taps_err", t2_err, 1'b0);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
